// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package riscv_fetch_pkg;

    localparam int CPU_WIDTH_DEFAULT   = 32;
    localparam int RAM_WIDTH_DEFAULT   = 31;
    localparam int FETCH_DEPTH_DEFAULT = 4;
    localparam int INSTR_BYTES         = 4;

    typedef struct packed {
        logic [RAM_WIDTH_DEFAULT-1:0] pc;
        logic [CPU_WIDTH_DEFAULT-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int fetch_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// Registered prefetch FIFO (no write-to-read bypass) holding {pc, instr} entries.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int  DEPTH   = FETCH_DEPTH_DEFAULT,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = fetch_cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          a_reset_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!a_reset_n)
        (push && !flush && full) |-> pop);

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-based in-order imem reads, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed event counters.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int                   CPU_WIDTH   = CPU_WIDTH_DEFAULT,
    parameter int                   RAM_WIDTH   = RAM_WIDTH_DEFAULT,
    parameter int                   FETCH_DEPTH = FETCH_DEPTH_DEFAULT,
    parameter logic [RAM_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                 clk,
    input  logic                 a_reset_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [RAM_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [RAM_WIDTH-1:0] dec_pc,
    output logic [CPU_WIDTH-1:0] dec_instr,
    input  logic                 redirect_valid,
    input  logic [RAM_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed
`endif
);

    localparam int                   CW          = fetch_cnt_width(FETCH_DEPTH);
    localparam logic [CW:0]          DEPTH_LIMIT = (CW+1)'(FETCH_DEPTH);
    localparam logic [RAM_WIDTH-1:0] PC_STEP     = RAM_WIDTH'(INSTR_BYTES);

    typedef struct packed {
        logic [RAM_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] instr;
    } entry_t;

    logic [RAM_WIDTH-1:0] fetch_pc;
    logic [RAM_WIDTH-1:0] rsp_pc;
    logic [RAM_WIDTH-1:0] redirect_target;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop_cnt;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          credit_used;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 req_fire;
    logic                 rsp_drop;
    logic                 rsp_keep;
    logic                 dec_pop;
    entry_t               fifo_head;
    entry_t               fifo_in;

    assign redirect_target = {redirect_pc[RAM_WIDTH-1:2], 2'b00};
    assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding};

    // Every in-flight request already owns a FIFO slot, so the FIFO can never overflow.
    assign imem_req_valid  = a_reset_n && !redirect_valid && (credit_used < DEPTH_LIMIT);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign rsp_drop        = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    assign rsp_keep        = imem_rsp_valid && !rsp_drop;
    assign fifo_in         = '{pc: rsp_pc, instr: imem_rsp_data};

    assign dec_valid       = !fifo_empty;
    assign dec_pc          = fifo_head.pc;
    assign dec_instr       = fifo_head.instr;
    assign dec_pop         = dec_valid && dec_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH   (FETCH_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .push      (rsp_keep),
        .push_data (fifo_in),
        .pop       (dec_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + PC_STEP;
            end
        end
    end

    // Everything still in flight at a redirect belongs to the old path and must be dropped.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(dec_pop);
            perf_flushed <= perf_flushed + 32'(fifo_count & {CW{redirect_valid}}) + 32'(rsp_drop);
        end
    end
`endif

    a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!a_reset_n)
        imem_rsp_valid |-> (outstanding != '0));

    a_fifo_never_full_on_push: assert property (@(posedge clk) disable iff (!a_reset_n)
        (rsp_keep && fifo_full) |-> dec_pop);

endmodule
